eth_frame_former_axis: RTL and testbench
========================================

// Module: eth_frame_former_axis
// PURPOSE
// - Builds raw Ethernet frames as a 64-bit AXI4-Stream, 8 bytes per beat.
// - Frame layout: 2 header beats (DST/SRC/LinkType/SyncWord), N payload beats pulled from
//   an upstream FIFO over AXIS, 1 fixed trailer beat.
// - Sits between the sample FIFO and the Ethernet MAC TX stream.
// - Has full ready/valid backpressure on both sides and a FIFO-level start gate, so a
//   frame never underruns. Payload length is set at runtime, with a parameterised maximum.
// PARAMETERS
// - MAX_BEATS     1024        max payload beats per frame
// - BEAT_W        11          width of payload_beats; must satisfy 2**BEAT_W > MAX_BEATS
// - LVL_W         16          width of fifo_level
// - TRAILER_DATA  64'h5704    tdata of trailer beat
// - TRAILER_KEEP  8'h07       tkeep of trailer beat
// PORTS
// - ACLK           in   1       clock
// - ARESETN        in   1       reset: synchronous, active-low
// - enable         in   1       allow new frames to start
// - fifo_level     in   LVL_W   words currently held in upstream FIFO
// - s_axis_tdata   in   64      payload word
// - s_axis_tvalid  in   1       payload valid
// - s_axis_tready  out  1       payload accepted this cycle
// - m_axis_tdata   out  64      frame data
// - m_axis_tkeep   out  8       byte enables
// - m_axis_tvalid  out  1       output valid
// - m_axis_tlast   out  1       last beat of frame
// - m_axis_tready  in   1       downstream ready
// - dst_addr       in   48      destination MAC
// - src_addr       in   48      source MAC
// - link_type      in   16      EtherType
// - sync_word      in   16      sync marker
// - payload_beats  in   BEAT_W  payload beats for next frame
// - frame_count    out  32      completed frames (trailer handshaken); wraps at 2^32
// - busy           out  1       1 when state != IDLE or m_axis_tvalid = 1
// - dbg_state      out  3       FSM state encoding
// BEHAVIOUR
// - Reset values:
//   - state = IDLE.
//   - m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep = 0.
//   - frame_count = 0; sequence counter = 0.
//   - Reset mid-frame abandons the frame; no tlast is emitted.
// - Output is a single register stage.
//   - load = !m_axis_tvalid || m_axis_tready.
//   - A beat is loaded only when load = 1.
//   - While tvalid = 1 and tready = 0, tdata, tkeep and tlast hold stable.
// - States: IDLE -> HDR1 -> [SEQ] -> PAYLOAD -> TRAILER -> IDLE.
//   - State names the next beat to be loaded.
// - IDLE:
//   - Frame starts when load && enable && fifo_level >= eff_beats.
//   - eff_beats = min(payload_beats, MAX_BEATS).
//   - On start, load beat0: tdata = {src_addr[15:0], dst_addr}, tkeep = FF.
//   - Latch dst/src/link_type/sync_word/eff_beats into frame registers.
//   - Inputs changing mid-frame have no effect.
//   - If the start condition is false, tvalid drops to 0 once the current beat is accepted.
// - HDR1:
//   - Load tdata = {sync_word, link_type, src_addr[47:16]}, tkeep = FF.
//   - eff_beats = 0 skips PAYLOAD and goes straight to TRAILER.
// - PAYLOAD:
//   - s_axis_tready = load (combinational) in this state only.
//   - On s_axis_tvalid && s_axis_tready: tdata = s_axis_tdata, tkeep = FF, beat counter + 1.
//   - Input not valid: load a bubble (tvalid = 0) and stay in PAYLOAD.
//   - Leave PAYLOAD after eff_beats accepted words.
// - TRAILER:
//   - Load tdata = TRAILER_DATA, tkeep = TRAILER_KEEP, tlast = 1.
//   - frame_count increments on the trailer's output handshake.
// - Back-to-back frames:
//   - If the start condition holds when the trailer is accepted, the next beat0 loads in
//     that same cycle: zero idle cycles.
// - enable deasserted mid-frame: the current frame completes; no new start.
// - s_axis_tready is 0 in every state except PAYLOAD.
// - Latency: beat0 appears on m_axis one cycle after the start condition.
// CONFIGURATION
// - Macro FRAME_SEQ_NUM_EN.
// - Defined: a SEQ state between HDR1 and PAYLOAD loads one extra beat.
//   - Beat content: tdata = {32'h0, seq[31:0]}, tkeep = FF.
//   - seq increments on each trailer handshake and wraps 2^32-1 -> 0.
//   - Frame length = eff_beats + 4.
// - Undefined: no SEQ state, no seq register; frame length = eff_beats + 3.
// TESTING
// - Reset, then payload_beats=4, level=4, tready=1, enable=1:
//   - Expect 7 beats: DST/SRC header, 4 payload words, trailer 64'h5704/keep 07 with tlast.
//   - frame_count = 1.
// - level=3 with payload_beats=4: no frame starts (tvalid stays 0); level -> 4 starts next cycle.
// - Backpressure: tready low 3 cycles in the middle of payload:
//   - tdata held stable, s_axis_tready = 0, no words lost or duplicated.
// - payload_beats=0: 3-beat frame (HDR0, HDR1, trailer); s_axis_tready never 1.
// - payload_beats=2000 with MAX_BEATS=1024: clamps to 1024 payload beats.
// - Continuous level=8, payload_beats=8: back-to-back frames with no gap cycles.
// - Reset asserted mid-payload: outputs clear next cycle; the following frame is intact.
// - With FRAME_SEQ_NUM_EN: beat 2 carries seq 0, 1, 2 on consecutive frames.

Source files
------------

// File: rtl/eth_frame_former_axis.sv
// Ethernet frame former: header beats, N payload beats from an upstream AXIS FIFO, fixed trailer.
// Optional macro FRAME_SEQ_NUM_EN inserts a 32-bit sequence-number beat after the header.
module eth_frame_former_axis #(
    parameter int          MAX_BEATS    = 1024,
    parameter int          BEAT_W       = 11,
    parameter int          LVL_W        = 16,
    parameter logic [63:0] TRAILER_DATA = 64'h5704,
    parameter logic [7:0]  TRAILER_KEEP = 8'h07
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              enable,
    input  logic [LVL_W-1:0]  fifo_level,
    input  logic [63:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [63:0]       m_axis_tdata,
    output logic [7:0]        m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    input  logic [47:0]       dst_addr,
    input  logic [47:0]       src_addr,
    input  logic [15:0]       link_type,
    input  logic [15:0]       sync_word,
    input  logic [BEAT_W-1:0] payload_beats,
    output logic [31:0]       frame_count,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR1    = 3'd1;
    localparam logic [2:0] S_SEQ     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_TRAILER = 3'd4;

    localparam logic [BEAT_W-1:0] MAX_B = BEAT_W'(MAX_BEATS);

    logic [2:0]        state;
    logic [BEAT_W-1:0] eff_in;
    logic [BEAT_W-1:0] f_eff;
    logic [BEAT_W-1:0] beat_cnt;
    // Only the fields needed after beat0 are latched; dst is fully consumed by beat0.
    logic [31:0]       f_src_hi;
    logic [15:0]       f_link;
    logic [15:0]       f_sync;
    logic              load;
    logic              start;
    logic              last_word;
    logic              trl_hs;
    logic [2:0]        hdr1_next;
`ifdef FRAME_SEQ_NUM_EN
    logic [31:0]       seq;
`endif

    assign eff_in        = (payload_beats > MAX_B) ? MAX_B : payload_beats;
    assign load          = !m_axis_tvalid || m_axis_tready;
    assign start         = load && enable && (32'(fifo_level) >= 32'(eff_in));
    assign last_word     = (beat_cnt + BEAT_W'(1)) == f_eff;
    assign trl_hs        = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign s_axis_tready = (state == S_PAYLOAD) && load;
    assign busy          = (state != S_IDLE) || m_axis_tvalid;
    assign dbg_state     = state;

`ifdef FRAME_SEQ_NUM_EN
    assign hdr1_next = S_SEQ;
`else
    assign hdr1_next = (f_eff == '0) ? S_TRAILER : S_PAYLOAD;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= S_IDLE;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_count   <= '0;
            f_eff         <= '0;
            beat_cnt      <= '0;
            f_src_hi      <= '0;
            f_link        <= '0;
            f_sync        <= '0;
`ifdef FRAME_SEQ_NUM_EN
            seq           <= '0;
`endif
        end else begin
            if (trl_hs) begin
                frame_count <= frame_count + 32'd1;
`ifdef FRAME_SEQ_NUM_EN
                seq         <= seq + 32'd1;
`endif
            end
            // State names the next beat; it only advances when the output register can take it.
            if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tkeep  <= 8'hFF;
                m_axis_tlast  <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            m_axis_tdata <= {src_addr[15:0], dst_addr};
                            f_src_hi     <= src_addr[47:16];
                            f_link       <= link_type;
                            f_sync       <= sync_word;
                            f_eff        <= eff_in;
                            state        <= S_HDR1;
                        end else begin
                            m_axis_tvalid <= 1'b0;
                        end
                    end
                    S_HDR1: begin
                        m_axis_tdata <= {f_sync, f_link, f_src_hi};
                        beat_cnt     <= '0;
                        state        <= hdr1_next;
                    end
`ifdef FRAME_SEQ_NUM_EN
                    S_SEQ: begin
                        m_axis_tdata <= {32'h0, seq};
                        state        <= (f_eff == '0) ? S_TRAILER : S_PAYLOAD;
                    end
`endif
                    S_PAYLOAD: begin
                        if (s_axis_tvalid) begin
                            m_axis_tdata <= s_axis_tdata;
                            beat_cnt     <= beat_cnt + BEAT_W'(1);
                            if (last_word)
                                state <= S_TRAILER;
                        end else begin
                            m_axis_tvalid <= 1'b0;
                        end
                    end
                    S_TRAILER: begin
                        m_axis_tdata <= TRAILER_DATA;
                        m_axis_tkeep <= TRAILER_KEEP;
                        m_axis_tlast <= 1'b1;
                        state        <= S_IDLE;
                    end
                    default: begin
                        m_axis_tvalid <= 1'b0;
                        state         <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_former_axis.sv
// Scoreboard bench for eth_frame_former_axis: expected beats queued per frame, compared on handshake.
module tb_eth_frame_former_axis;

    localparam int MAXB = 1024;
    localparam int BW   = 11;
    localparam int LW   = 16;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          enable = 1'b0;
    logic [LW-1:0] fifo_level = '0;
    logic [63:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [63:0]   m_axis_tdata;
    logic [7:0]    m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [47:0]   dst_addr;
    logic [47:0]   src_addr;
    logic [15:0]   link_type;
    logic [15:0]   sync_word;
    logic [BW-1:0] payload_beats = '0;
    logic [31:0]   frame_count;
    logic          busy;
    logic [2:0]    dbg_state;

    eth_frame_former_axis #(.MAX_BEATS(MAXB), .BEAT_W(BW), .LVL_W(LW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .fifo_level(fifo_level),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .dst_addr(dst_addr), .src_addr(src_addr), .link_type(link_type), .sync_word(sync_word),
        .payload_beats(payload_beats), .frame_count(frame_count), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 ACLK = ~ACLK;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t sb[$];
    int    src_idx = 0;
    int    plan_idx = 0;
    int    exp_fc = 0;
    int    exp_seq = 0;
    int    beats_seen = 0;
    int    frames_started = 0;
    int    cyc = 0;
    int    trl_cyc = 0;
    bit    in_frame = 0;
    bit    after_trl = 0;
    bit    chk_gap = 0;
    bit    srdy_seen = 0;
    bit    src_gap = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word(input int i);
        return {32'hC0DE0000, 32'(i)};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        sb.push_back(b);
    endtask

    task automatic push_frame(input int eff);
        push_beat({src_addr[15:0], dst_addr}, 8'hFF, 1'b0);
        push_beat({sync_word, link_type, src_addr[47:16]}, 8'hFF, 1'b0);
`ifdef FRAME_SEQ_NUM_EN
        push_beat({32'h0, 32'(exp_seq)}, 8'hFF, 1'b0);
        exp_seq++;
`endif
        for (int i = 0; i < eff; i++) begin
            push_beat(word(plan_idx), 8'hFF, 1'b0);
            plan_idx++;
        end
        push_beat(64'h5704, 8'h07, 1'b1);
        exp_fc++;
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < bound) begin
            tick();
            n++;
        end
        chk("drain", 64'(n < bound), 64'd1);
        chk("frame_count", frame_count, 64'(exp_fc));
    endtask

    // Output monitor: a beat transfers at the posedge following a negedge with valid && ready.
    initial forever begin
        beat_t e;
        @(negedge ACLK);
        cyc++;
        if (ARESETN && s_axis_tready) srdy_seen = 1;
        if (ARESETN && m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("tdata", m_axis_tdata, e.d);
                chk("tkeep", 64'(m_axis_tkeep), 64'(e.k));
                chk("tlast", 64'(m_axis_tlast), 64'(e.l));
            end
            beats_seen++;
            if (!in_frame) begin
                frames_started++;
                in_frame = 1;
            end
            if (after_trl && chk_gap) chk("b2b_gap", 64'(cyc - trl_cyc), 64'd1);
            after_trl = 0;
            if (m_axis_tlast) begin
                in_frame  = 0;
                after_trl = 1;
                trl_cyc   = cyc;
            end
        end
    end

    // Payload source: word index advances once per accepted word.
    initial begin
        bit tk;
        s_axis_tdata  = word(0);
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge ACLK);
            tk = ARESETN && s_axis_tvalid && s_axis_tready;
            @(posedge ACLK);
            #1;
            if (tk) src_idx++;
            s_axis_tdata  = word(src_idx);
            s_axis_tvalid = !src_gap || ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] held;
        int n, base;
        dst_addr  = 48'h0011_2233_4455;
        src_addr  = 48'hA0B1_C2D3_E4F5;
        link_type = 16'h88B5;
        sync_word = 16'hFEED;
        repeat (3) tick();
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("rst_fc", 64'(frame_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        chk("rst_sready", 64'(s_axis_tready), 64'd0);
        ARESETN = 1'b1;
        tick();

        // Basic 4-word frame; header inputs changed mid-frame must not leak in.
        payload_beats = 4;
        fifo_level    = 4;
        push_frame(4);
        pulse_enable();
        chk("latency", 64'(m_axis_tvalid), 64'd1);
        dst_addr  = 48'hDEAD_BEEF_0001;
        src_addr  = 48'h1234_5678_9ABC;
        link_type = 16'h0800;
        wait_idle(50);

        // Level gate: 3 < 4 holds off, 4 starts on the next cycle.
        fifo_level = 3;
        enable     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gate_tvalid", 64'(m_axis_tvalid), 64'd0);
        end
        push_frame(4);
        fifo_level = 4;
        tick();
        chk("gate_start", 64'(m_axis_tvalid), 64'd1);
        enable = 1'b0;
        wait_idle(50);

        // Backpressure mid-payload with a gappy source.
        payload_beats = 8;
        fifo_level    = 8;
        src_gap       = 1;
        base = beats_seen;
        push_frame(8);
        pulse_enable();
        n = 0;
        while (!(beats_seen >= base + 4 && m_axis_tvalid) && n < 100) begin
            tick();
            n++;
        end
        chk("bp_reach", 64'(n < 100), 64'd1);
        m_axis_tready = 1'b0;
        held = m_axis_tdata;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", m_axis_tdata, held);
            chk("bp_valid", 64'(m_axis_tvalid), 64'd1);
            chk("bp_sready", 64'(s_axis_tready), 64'd0);
        end
        m_axis_tready = 1'b1;
        wait_idle(100);
        src_gap = 0;

        // Zero payload: header + trailer only, source never asked.
        payload_beats = 0;
        fifo_level    = 0;
        srdy_seen     = 0;
        push_frame(0);
        pulse_enable();
        wait_idle(50);
        chk("zero_sready", 64'(srdy_seen), 64'd0);

        // Clamp 2000 -> MAX_BEATS.
        payload_beats = 2000;
        fifo_level    = 2000;
        push_frame(MAXB);
        pulse_enable();
        wait_idle(1200);

        // Back-to-back frames, enable dropped during the third.
        payload_beats = 8;
        fifo_level    = 8;
        push_frame(8);
        push_frame(8);
        push_frame(8);
        after_trl = 0;
        chk_gap   = 1;
        base      = frames_started;
        enable    = 1'b1;
        n = 0;
        while (frames_started < base + 3 && n < 100) begin
            tick();
            n++;
        end
        chk("b2b_reach", 64'(n < 100), 64'd1);
        enable = 1'b0;
        wait_idle(100);
        chk_gap = 0;

        // Reset mid-payload, then a clean frame.
        base = beats_seen;
        push_frame(8);
        pulse_enable();
        n = 0;
        while (beats_seen < base + 4 && n < 100) begin
            tick();
            n++;
        end
        chk("rst_reach", 64'(n < 100), 64'd1);
        ARESETN = 1'b0;
        tick();
        chk("mrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mrst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("mrst_tdata", m_axis_tdata, 64'd0);
        chk("mrst_fc", 64'(frame_count), 64'd0);
        chk("mrst_state", 64'(dbg_state), 64'd0);
        sb.delete();
        in_frame  = 0;
        after_trl = 0;
        exp_fc    = 0;
        exp_seq   = 0;
        ARESETN   = 1'b1;
        plan_idx  = src_idx;
        tick();
        push_frame(8);
        pulse_enable();
        wait_idle(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
